// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32I control unit: ID decode into an ID/EX control register, load-use stall, EX redirect.
// Optional saturating performance counters are compiled in with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl_unit #(
  parameter int ALU_CTRL_W = 4,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr_d,
  input  logic                  valid_d,
  input  logic                  eq_e,
  input  logic                  lt_e,
  input  logic                  ltu_e,
  output logic [2:0]            imm_src_d,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic [1:0]            pcsrc_e,
  output logic                  valid_e,
  output logic                  reg_write_e,
  output logic                  mem_write_e,
  output logic                  mem_read_e,
  output logic                  byte_addr_e,
  output logic                  alu_src_e,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
  output logic [1:0]            result_src_e,
  output logic [REG_ADDR_W-1:0] rd_e,
  output logic                  illegal_e
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      illegal_cnt
`endif
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_read;
    logic                  byte_addr;
    logic                  alu_src;
    alu_op_e               alu_op;
    logic [1:0]            result_src;
    logic [REG_ADDR_W-1:0] rd;
    logic                  illegal;
    logic                  branch;
    logic                  jal;
    logic                  jalr;
    logic [2:0]            funct3;
  } ctl_t;

  function automatic alu_op_e alu_op_f(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op_f = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op_f = ALU_SLL;
      3'b010:  alu_op_f = ALU_SLT;
      3'b011:  alu_op_f = ALU_SLTU;
      3'b100:  alu_op_f = ALU_XOR;
      3'b101:  alu_op_f = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op_f = ALU_OR;
      default: alu_op_f = ALU_AND;
    endcase
  endfunction

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  r_funct_ok;
  logic                  uses_rs1;
  logic                  uses_rs2;
  logic                  load_use;
  logic                  cond;
  logic                  taken;
  ctl_t                  dec;
  ctl_t                  ctl_d;
  ctl_t                  ctl_q;

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign funct7 = instr_d[31:25];
  assign rs1    = REG_ADDR_W'(instr_d[19:15]);
  assign rs2    = REG_ADDR_W'(instr_d[24:20]);

  // Only add/sub and srl/sra have an alternate funct7 encoding.
  assign r_funct_ok = (funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

  // NOTE: every always_comb output gets a default before the case, so no path infers a latch.
  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec.rd     = REG_ADDR_W'(instr_d[11:7]);
    dec.funct3 = funct3;
    imm_src_d  = 3'b000;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    case (opcode)
      OP_R: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        if (r_funct_ok) begin
          dec.reg_write = 1'b1;
          dec.alu_op    = alu_op_f(funct3, funct7[5]);
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_I: begin
        uses_rs1      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = alu_op_f(funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OP_LOAD: begin
        uses_rs1       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_src    = 1'b1;
        dec.byte_addr  = (funct3 == 3'b100);
        dec.result_src = 2'b01;
      end
      OP_STORE: begin
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.byte_addr = (funct3 == 3'b000);
        imm_src_d     = 3'b001;
      end
      OP_BRANCH: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        imm_src_d = 3'b010;
        if ((funct3 == 3'b010) || (funct3 == 3'b011)) begin
          dec.illegal = 1'b1;
        end else begin
          dec.branch = 1'b1;
          dec.alu_op = ALU_SUB;
        end
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jal        = 1'b1;
        dec.result_src = 2'b10;
        imm_src_d      = 3'b011;
      end
      OP_JALR: begin
        uses_rs1       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.jalr       = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b10;
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b11;
        imm_src_d      = 3'b100;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign load_use = valid_d && ctl_q.valid && ctl_q.mem_read && (ctl_q.rd != '0) &&
                    ((uses_rs1 && (rs1 == ctl_q.rd)) || (uses_rs2 && (rs2 == ctl_q.rd)));

  always_comb begin
    cond = 1'b0;
    case (ctl_q.funct3)
      3'b000:  cond = eq_e;
      3'b001:  cond = !eq_e;
      3'b100:  cond = lt_e;
      3'b101:  cond = !lt_e;
      3'b110:  cond = ltu_e;
      3'b111:  cond = !ltu_e;
      default: cond = 1'b0;
    endcase
  end

  assign taken = ctl_q.valid && (ctl_q.jal || ctl_q.jalr || (ctl_q.branch && cond));

  // A redirect discards the ID instruction, so it overrides any load-use stall.
  assign stall_f = load_use && !taken;
  assign stall_d = load_use && !taken;
  assign flush_d = taken;
  assign pcsrc_e = taken ? (ctl_q.jalr ? 2'b10 : 2'b01) : 2'b00;

  assign ctl_d = (!valid_d || taken || load_use) ? '0 : dec;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q <= '0;
    end else begin
      ctl_q <= ctl_d;
    end
  end

  assign valid_e      = ctl_q.valid;
  assign reg_write_e  = ctl_q.reg_write;
  assign mem_write_e  = ctl_q.mem_write;
  assign mem_read_e   = ctl_q.mem_read;
  assign byte_addr_e  = ctl_q.byte_addr;
  assign alu_src_e    = ctl_q.alu_src;
  assign alu_ctrl_e   = ALU_CTRL_W'(ctl_q.alu_op);
  assign result_src_e = ctl_q.result_src;
  assign rd_e         = ctl_q.rd;
  assign illegal_e    = ctl_q.illegal;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] illegal_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      illegal_cnt_q <= '0;
    end else begin
      if (stall_d && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_d && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (illegal_e && (illegal_cnt_q != '1)) illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
`else
  // Counter width only matters when the counters are built.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed hazard/redirect/illegal/reset steps, then
// randomized instruction streams compared against a rule-level pipeline model.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d;
  logic        valid_d, eq_e, lt_e, ltu_e;
  logic [2:0]  imm_src_d;
  logic        stall_f, stall_d, flush_d;
  logic [1:0]  pcsrc_e;
  logic        valid_e, reg_write_e, mem_write_e, mem_read_e, byte_addr_e, alu_src_e;
  logic [3:0]  alu_ctrl_e;
  logic [1:0]  result_src_e;
  logic [4:0]  rd_e;
  logic        illegal_e;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, illegal_cnt;
`endif

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d),
    .eq_e(eq_e), .lt_e(lt_e), .ltu_e(ltu_e), .imm_src_d(imm_src_d),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .pcsrc_e(pcsrc_e),
    .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .mem_read_e(mem_read_e), .byte_addr_e(byte_addr_e), .alu_src_e(alu_src_e),
    .alu_ctrl_e(alu_ctrl_e), .result_src_e(result_src_e), .rd_e(rd_e),
    .illegal_e(illegal_e)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .illegal_cnt(illegal_cnt)
`endif
  );

  localparam int K_NONE = 0, K_BR = 1, K_JAL = 2, K_JALR = 3;

  typedef struct {
    int valid, reg_write, mem_write, mem_read, byte_addr, alu_src, illegal;
    int alu, result_src, rd, kind, f3, imm_src, use1, use2, rs1, rs2;
  } exp_t;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t m_ex;
  int   c_stall, c_flush, c_ill;
  logic obs_stall, obs_flush;
  logic [1:0] obs_pcsrc;
  bit   exp_stall_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e = '{default: 0};
    return e;
  endfunction

  // Mnemonic table: index = {alt funct7 bit, funct3}; -1 marks an undefined R-type combination.
  function automatic int r_code(input int idx);
    case (idx)
      0: return 0;  8: return 1;  7: return 2;  6: return 3;  4: return 4;
      2: return 5;  3: return 6;  1: return 7;  5: return 8;  13: return 9;
      default: return -1;
    endcase
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e = bubble();
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    int code;
    e.valid = 1; e.rd = int'(ins[11:7]); e.rs1 = int'(ins[19:15]); e.rs2 = int'(ins[24:20]);
    e.f3 = int'(f3);
    case (op)
      7'h33: begin
        e.use1 = 1; e.use2 = 1;
        if (f7 == 7'h00)      code = r_code(int'(f3));
        else if (f7 == 7'h20) code = r_code(8 + int'(f3));
        else                  code = -1;
        if (code < 0) e.illegal = 1;
        else begin e.reg_write = 1; e.alu = code; end
      end
      7'h13: begin
        e.use1 = 1; e.reg_write = 1; e.alu_src = 1;
        e.alu = r_code(((f3 == 3'd5) && ins[30]) ? 8 + int'(f3) : int'(f3));
      end
      7'h03: begin
        e.use1 = 1; e.reg_write = 1; e.mem_read = 1; e.alu_src = 1;
        e.byte_addr = (f3 == 3'd4) ? 1 : 0; e.result_src = 1;
      end
      7'h23: begin
        e.use1 = 1; e.use2 = 1; e.mem_write = 1; e.alu_src = 1;
        e.byte_addr = (f3 == 3'd0) ? 1 : 0; e.imm_src = 1;
      end
      7'h63: begin
        e.use1 = 1; e.use2 = 1; e.imm_src = 2;
        if (f3 == 3'd2 || f3 == 3'd3) e.illegal = 1;
        else begin e.kind = K_BR; e.alu = 1; end
      end
      7'h6f: begin e.reg_write = 1; e.result_src = 2; e.imm_src = 3; e.kind = K_JAL; end
      7'h67: begin
        e.use1 = 1; e.reg_write = 1; e.result_src = 2; e.alu_src = 1; e.kind = K_JALR;
      end
      7'h37: begin e.reg_write = 1; e.result_src = 3; e.imm_src = 4; end
      default: e.illegal = 1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs2, rs1, input logic [2:0] f3);
    return {7'h00, rs2, rs1, f3, 5'h04, 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, rs2);
    return {7'h00, rs2, rs1, f3, 5'b01000, 7'h63};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    logic [2:0] f;
    int k;
    a = 5'($urandom_range(0, 6));
    b = 5'($urandom_range(0, 6));
    c = 5'($urandom_range(0, 6));
    f = 3'($urandom);
    k = $urandom_range(0, 9);
    case (k)
      0: return enc_r(($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00, b, a, f, c);
      1: return enc_r(7'($urandom), b, a, f, c);
      2: return enc_i(12'($urandom), a, f, c, 7'h13);
      3, 4: return enc_i(12'($urandom), a, ($urandom_range(0, 1) != 0) ? 3'b010 : 3'b100, c, 7'h03);
      5: return enc_s(b, a, ($urandom_range(0, 1) != 0) ? 3'b000 : 3'b010);
      6: return enc_b(f, a, b);
      7: return ($urandom_range(0, 1) != 0) ? {20'($urandom), c, 7'h6f} : {20'($urandom), c, 7'h37};
      8: return enc_i(12'h000, a, 3'b000, c, 7'h67);
      default: return $urandom;
    endcase
  endfunction

  task automatic check_ex();
    check("valid_e",      32'(valid_e),      m_ex.valid);
    check("reg_write_e",  32'(reg_write_e),  m_ex.reg_write);
    check("mem_write_e",  32'(mem_write_e),  m_ex.mem_write);
    check("mem_read_e",   32'(mem_read_e),   m_ex.mem_read);
    check("byte_addr_e",  32'(byte_addr_e),  m_ex.byte_addr);
    check("alu_src_e",    32'(alu_src_e),    m_ex.alu_src);
    check("alu_ctrl_e",   32'(alu_ctrl_e),   m_ex.alu);
    check("result_src_e", 32'(result_src_e), m_ex.result_src);
    check("rd_e",         32'(rd_e),         m_ex.rd);
    check("illegal_e",    32'(illegal_e),    m_ex.illegal);
  endtask

  // One pipeline cycle: drive ID inputs, check combinational outputs, clock, check ID/EX state.
  task automatic step(input logic [31:0] ins, input bit v, input bit eq, input bit lt, input bit ltu);
    exp_t d;
    bit   cond, taken, lu;
    int   pc;
    instr_d = ins; valid_d = v; eq_e = eq; lt_e = lt; ltu_e = ltu;
    #2;
    d = ref_decode(ins);
    case (m_ex.f3)
      0: cond = eq;   1: cond = !eq;
      4: cond = lt;   5: cond = !lt;
      6: cond = ltu;  7: cond = !ltu;
      default: cond = 0;
    endcase
    taken = (m_ex.valid != 0) &&
            (m_ex.kind == K_JAL || m_ex.kind == K_JALR || (m_ex.kind == K_BR && cond));
    lu = v && (m_ex.valid != 0) && (m_ex.mem_read != 0) && (m_ex.rd != 0) &&
         ((d.use1 != 0 && d.rs1 == m_ex.rd) || (d.use2 != 0 && d.rs2 == m_ex.rd));
    exp_stall_last = lu && !taken;
    pc = !taken ? 0 : (m_ex.kind == K_JALR) ? 2 : 1;
    check("imm_src_d", 32'(imm_src_d), d.imm_src);
    check("stall_f",   32'(stall_f),   32'(exp_stall_last));
    check("stall_d",   32'(stall_d),   32'(exp_stall_last));
    check("flush_d",   32'(flush_d),   32'(taken));
    check("pcsrc_e",   32'(pcsrc_e),   pc);
    obs_stall = stall_d; obs_flush = flush_d; obs_pcsrc = pcsrc_e;
    if (exp_stall_last) c_stall++;
    if (taken) c_flush++;
    if (m_ex.illegal != 0) c_ill++;
    @(posedge clk);
    #1;
    m_ex = (!v || taken || lu) ? bubble() : d;
    check_ex();
`ifdef PIPE_CTRL_PERF_EN
    check("stall_cnt",   stall_cnt,   c_stall);
    check("flush_cnt",   flush_cnt,   c_flush);
    check("illegal_cnt", illegal_cnt, c_ill);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] cur;
    logic [31:0] nop, lw_x5, add_dep, lw_x0, add_x0;
    nop     = enc_i(12'h000, 5'd0, 3'b000, 5'd0, 7'h13);
    lw_x5   = enc_i(12'h000, 5'd1, 3'b010, 5'd5, 7'h03);
    add_dep = enc_r(7'h00, 5'd2, 5'd5, 3'b000, 5'd6);
    lw_x0   = enc_i(12'h000, 5'd1, 3'b010, 5'd0, 7'h03);
    add_x0  = enc_r(7'h00, 5'd2, 5'd0, 3'b000, 5'd6);

    rst = 1'b1; instr_d = 32'h0; valid_d = 1'b1; eq_e = 1'b1; lt_e = 1'b1; ltu_e = 1'b1;
    m_ex = bubble(); c_stall = 0; c_flush = 0; c_ill = 0;
    #1;
    check_ex();
    check("rst_stall_d", 32'(stall_d), 0);
    check("rst_flush_d", 32'(flush_d), 0);
    check("rst_pcsrc_e", 32'(pcsrc_e), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load-use: one stall cycle, one bubble, then the dependent add proceeds.
    step(lw_x5, 1, 0, 0, 0);
    step(add_dep, 1, 0, 0, 0);
    check("lu_stall_d", 32'(obs_stall), 1);
    check("lu_bubble_valid_e", 32'(valid_e), 0);
    step(add_dep, 1, 0, 0, 0);
    check("lu_resume_stall_d", 32'(obs_stall), 0);
    check("lu_add_alu_ctrl", 32'(alu_ctrl_e), 0);
    check("lu_add_reg_write", 32'(reg_write_e), 1);

    // Load to x0 never stalls.
    step(lw_x0, 1, 0, 0, 0);
    step(add_x0, 1, 0, 0, 0);
    check("x0_no_stall", 32'(obs_stall), 0);
    check("x0_valid_e", 32'(valid_e), 1);

    // Branches resolved in EX.
    step(enc_b(3'b000, 5'd1, 5'd2), 1, 0, 0, 0);
    step(nop, 1, 1, 0, 0);
    check("beq_pcsrc", 32'(obs_pcsrc), 1);
    check("beq_flush", 32'(obs_flush), 1);
    check("beq_bubble", 32'(valid_e), 0);
    step(enc_b(3'b001, 5'd1, 5'd2), 1, 0, 0, 0);
    step(nop, 1, 1, 0, 0);
    check("bne_pcsrc", 32'(obs_pcsrc), 0);
    check("bne_flush", 32'(obs_flush), 0);
    step(enc_b(3'b110, 5'd1, 5'd2), 1, 0, 0, 0);
    step(nop, 1, 0, 0, 1);
    check("bltu_pcsrc", 32'(obs_pcsrc), 1);

    // jalr that itself waited on a load, then redirects while a dependent add sits in ID.
    step(lw_x5, 1, 0, 0, 0);
    step(enc_i(12'h000, 5'd5, 3'b000, 5'd7, 7'h67), 1, 0, 0, 0);
    check("jalr_lu_stall", 32'(obs_stall), 1);
    step(enc_i(12'h000, 5'd5, 3'b000, 5'd7, 7'h67), 1, 0, 0, 0);
    step(enc_r(7'h00, 5'd2, 5'd7, 3'b000, 5'd6), 1, 0, 0, 0);
    check("jalr_pcsrc", 32'(obs_pcsrc), 2);
    check("jalr_flush", 32'(obs_flush), 1);
    check("jalr_stall", 32'(obs_stall), 0);

    // Illegal instructions enter EX valid with all enables off.
    step(32'h0000_0000, 1, 0, 0, 0);
    check("ill0_illegal", 32'(illegal_e), 1);
    check("ill0_valid", 32'(valid_e), 1);
    check("ill0_reg_write", 32'(reg_write_e), 0);
    step(enc_b(3'b010, 5'd1, 5'd2), 1, 0, 0, 0);
    check("illb_illegal", 32'(illegal_e), 1);
    check("illb_mem_write", 32'(mem_write_e), 0);
    step(nop, 1, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
    check("illegal_cnt_2", illegal_cnt, 2);
`endif

    // Randomized streams; a stalled ID instruction is re-presented as the IF/ID register would.
    exp_stall_last = 0;
    cur = nop;
    for (int i = 0; i < 400; i++) begin
      if (!exp_stall_last) cur = rand_instr();
      step(cur, $urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset asserted during a load-use stall clears everything asynchronously.
    step(lw_x5, 1, 0, 0, 0);
    instr_d = add_dep; valid_d = 1'b1;
    #2;
    check("pre_rst_stall_d", 32'(stall_d), 1);
    rst = 1'b1;
    #1;
    m_ex = bubble(); c_stall = 0; c_flush = 0; c_ill = 0;
    check_ex();
    check("mid_rst_stall_d", 32'(stall_d), 0);
    check("mid_rst_stall_f", 32'(stall_f), 0);
`ifdef PIPE_CTRL_PERF_EN
    check("mid_rst_stall_cnt", stall_cnt, 0);
    check("mid_rst_flush_cnt", flush_cnt, 0);
    check("mid_rst_illegal_cnt", illegal_cnt, 0);
`endif
    valid_d = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_ex();
    step(add_dep, 1, 0, 0, 0);
    check("post_rst_no_stall", 32'(obs_stall), 0);
    step(nop, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
